// File: rtl/gray_mon_pkg.sv
// Shared constants for the Gray sequence monitor: FSM encoding, error codes
// and a width-generic Gray-to-binary helper.
`timescale 1ns/1ps
package gray_mon_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_JUMP = 2'b01;
  localparam logic [1:0] ERR_BACK = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  localparam int G2B_MAXW = 16;

  // Each binary bit is the XOR of all Gray bits at or above it, which is the
  // closed form of b[i] = b[i+1] ^ g[i]; bits at or above w are masked off.
  function automatic logic [G2B_MAXW-1:0] gray2bin(input logic [G2B_MAXW-1:0] g,
                                                  input int unsigned w);
    logic [G2B_MAXW-1:0] gm;
    logic [G2B_MAXW-1:0] b;
    gm = (w >= G2B_MAXW) ? g : (g & ((G2B_MAXW'(1) << w) - G2B_MAXW'(1)));
    b  = '0;
    for (int i = 0; i < G2B_MAXW; i++) b[i] = ^(gm >> i);
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_w.sv
// Combinational W-bit Gray-to-binary converter.
`timescale 1ns/1ps
module gray2bin_w
  import gray_mon_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic [G2B_MAXW-1:0] full;

  assign full = gray2bin(G2B_MAXW'(gray), W);
  assign bin  = full[W-1:0];

endmodule

// File: rtl/gray_seq_monitor.sv
// Watches an upstream Gray counter: registered binary, forward-step pulse,
// saturating wrap count and a sticky first-violation code.
`timescale 1ns/1ps
module gray_seq_monitor
  import gray_mon_pkg::*;
#(
  parameter int W         = 3,
  parameter int WCNT_W    = 8,
  parameter int OVF_CHECK = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr,
  input  logic [W-1:0]      GrayIn,
  input  logic              OverflowIn,
  output logic [W-1:0]      Bin,
  output logic              Step,
  output logic [WCNT_W-1:0] WrapCount,
  output logic              Error,
  output logic [1:0]        ErrCode
);

  localparam logic [W-1:0] MAXB = '1;

  logic [W-1:0] cur_bin;
  logic [W-1:0] d;
  logic [1:0]   state;
  logic         seen_wrap;
  logic         fwd, back, jump, wrap, seen_nxt, ovf_bad;
  logic [1:0]   code;

  gray2bin_w #(.W(W)) u_g2b (
    .gray (GrayIn),
    .bin  (cur_bin)
  );

  // Bin doubles as the previous sample, so the step size is a plain subtract.
  assign d        = cur_bin - Bin;
  assign fwd      = (d == W'(1));
  assign back     = (d == MAXB);
  assign jump     = !fwd && !back && (d != '0);
  assign wrap     = fwd && (cur_bin == '0);
  assign seen_nxt = seen_wrap | wrap;
  assign ovf_bad  = (OVF_CHECK != 0) && (OverflowIn != seen_nxt);

  always_comb begin
    code = ERR_NONE;
    if (jump)         code = ERR_JUMP;
    else if (back)    code = ERR_BACK;
    else if (ovf_bad) code = ERR_OVF;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Bin       <= '0;
      Step      <= 1'b0;
      WrapCount <= '0;
      Error     <= 1'b0;
      ErrCode   <= ERR_NONE;
      seen_wrap <= 1'b0;
    end else begin
      Bin  <= cur_bin;
      Step <= 1'b0;
      // Mirror the upstream sticky overflow even while faulted, so a later
      // Clr resumes checking against the flag the counter actually holds.
      if (state != IDLE && wrap) seen_wrap <= 1'b1;
      if (Clr) begin
        state     <= IDLE;
        WrapCount <= '0;
        Error     <= 1'b0;
        ErrCode   <= ERR_NONE;
      end else begin
        case (state)
          IDLE: state <= TRACK;
          TRACK: begin
            if (code != ERR_NONE) begin
              Error   <= 1'b1;
              ErrCode <= code;
              state   <= FAULT;
            end else begin
              Step <= fwd;
              if (wrap && WrapCount != '1) WrapCount <= WrapCount + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Directed bench for gray_seq_monitor: one instance with overflow checking,
// one without, both driven from the same stimulus.
`timescale 1ns/1ps
module tb_gray_seq_monitor;

  logic       Clk = 1'b0;
  logic       Reset, Clr, OverflowIn;
  logic [2:0] GrayIn;

  logic [2:0] bin1, bin0;
  logic       step1, step0, err1, err0;
  logic [7:0] wc1, wc0;
  logic [1:0] ec1, ec0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                          3'b110, 3'b111, 3'b101, 3'b100};

  always #5 Clk = ~Clk;

  gray_seq_monitor #(.W(3), .WCNT_W(8), .OVF_CHECK(1)) dut (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
    .Bin(bin1), .Step(step1), .WrapCount(wc1), .Error(err1), .ErrCode(ec1));

  gray_seq_monitor #(.W(3), .WCNT_W(8), .OVF_CHECK(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
    .Bin(bin0), .Step(step0), .WrapCount(wc0), .Error(err0), .ErrCode(ec0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample at the falling edge; return just after the rising edge
  // that captured it.
  task automatic cyc(input logic [2:0] g, input logic o, input logic c);
    @(negedge Clk);
    GrayIn = g; OverflowIn = o; Clr = c;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; Clr = 1'b0; GrayIn = '0; OverflowIn = 1'b0;
    #3;
    Reset = 1'b0;
  endtask

  initial begin
    logic sw;
    Reset = 1'b1; Clr = 1'b0; GrayIn = '0; OverflowIn = 1'b0;
    #30;
    chk("rst_bin",  bin1,  0);
    chk("rst_step", step1, 0);
    chk("rst_wc",   wc1,   0);
    chk("rst_err",  err1,  0);
    chk("rst_ec",   ec1,   0);
    Reset = 1'b0;

    // full legal sequence with overflow rising on the wrap
    cyc(3'b000, 1'b0, 1'b0);
    chk("idle_bin",  bin1,  0);
    chk("idle_step", step1, 0);
    for (int i = 1; i < 8; i++) begin
      cyc(seq[i], 1'b0, 1'b0);
      chk("seq_bin",  bin1,  i);
      chk("seq_step", step1, 1);
    end
    cyc(3'b000, 1'b1, 1'b0);
    chk("wrap_bin",  bin1,  0);
    chk("wrap_step", step1, 1);
    chk("wrap_wc",   wc1,   1);
    chk("wrap_err",  err1,  0);

    // hold mid-sequence
    cyc(3'b001, 1'b1, 1'b0);
    cyc(3'b011, 1'b1, 1'b0);
    chk("pre_hold_step", step1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(3'b011, 1'b1, 1'b0);
      chk("hold_step", step1, 0);
      chk("hold_bin",  bin1,  2);
      chk("hold_err",  err1,  0);
    end

    // jump 3 -> 7, then a legal wrap while faulted must not count
    cyc(3'b010, 1'b1, 1'b0);
    cyc(3'b100, 1'b1, 1'b0);
    chk("jump_err",  err1,  1);
    chk("jump_ec",   ec1,   2'b01);
    chk("jump_step", step1, 0);
    chk("jump_wc",   wc1,   1);
    cyc(3'b000, 1'b1, 1'b0);
    chk("fault_bin",  bin1,  0);
    chk("fault_step", step1, 0);
    chk("fault_wc",   wc1,   1);
    chk("fault_ec",   ec1,   2'b01);

    // Clr, then legal codes resume tracking
    cyc(3'b001, 1'b1, 1'b1);
    chk("clr_err", err1, 0);
    chk("clr_ec",  ec1,  0);
    chk("clr_wc",  wc1,  0);
    chk("clr_bin", bin1, 1);
    cyc(3'b011, 1'b1, 1'b0);
    chk("clr_idle_step", step1, 0);
    cyc(3'b010, 1'b1, 1'b0);
    chk("clr_track_step", step1, 1);
    chk("clr_track_err",  err1,  0);

    // backward 3 -> 2, then a jump must not overwrite the code
    cyc(3'b011, 1'b1, 1'b0);
    chk("back_err", err1, 1);
    chk("back_ec",  ec1,  2'b10);
    cyc(3'b100, 1'b1, 1'b0);
    chk("back_hold_ec", ec1, 2'b10);

    // wrap with OverflowIn held low
    do_reset();
    for (int i = 0; i < 8; i++) cyc(seq[i], 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    chk("ovf_lo_err",   err1,  1);
    chk("ovf_lo_ec",    ec1,   2'b11);
    chk("ovf_lo_wc",    wc1,   0);
    chk("ovf_lo_err0",  err0,  0);
    chk("ovf_lo_wc0",   wc0,   1);
    chk("ovf_lo_step0", step0, 1);

    // OverflowIn high before any wrap
    do_reset();
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b001, 1'b1, 1'b0);
    chk("ovf_early_ec",    ec1,   2'b11);
    chk("ovf_early_err0",  err0,  0);
    chk("ovf_early_step0", step0, 1);

    // jump and overflow mismatch on one sample: jump wins
    do_reset();
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b010, 1'b1, 1'b0);
    chk("prio_ec",  ec1, 2'b01);
    chk("prio_ec0", ec0, 2'b01);

    // 300 legal wraps saturate the counter
    do_reset();
    cyc(3'b000, 1'b0, 1'b0);
    sw = 1'b0;
    for (int w = 0; w < 300; w++) begin
      for (int i = 1; i <= 8; i++) begin
        if (i == 8) sw = 1'b1;
        cyc(seq[i % 8], sw, 1'b0);
      end
      if (w == 254) chk("sat_255", wc1, 8'd255);
    end
    chk("sat_wc",   wc1,  8'd255);
    chk("sat_err",  err1, 0);
    chk("sat_wc0",  wc0,  8'd255);

    // asynchronous reset between edges
    cyc(3'b001, 1'b1, 1'b0);
    chk("pre_async_bin", bin1, 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_bin",  bin1,  0);
    chk("async_step", step1, 0);
    chk("async_wc",   wc1,   0);
    chk("async_err",  err1,  0);
    chk("async_ec",   ec1,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_seq_monitor.md
Name: gray_seq_monitor

Overview:
- Downstream consumer of the 3-bit Gray counter stage. Samples the counter's Gray output and overflow flag every clock.
- Produces the registered binary equivalent, a forward-step pulse and a wrap count.
- Checks that the sequence is legal: hold, or exactly one forward Gray step. Flags the first violation stickily so benches and later stages can trust the count.

Parameters:
- W, 3, Gray/binary width; the sequence length is 2**W.
- WCNT_W, 8, width of the wrap counter.
- OVF_CHECK, 1, 1 enables checking of OverflowIn against observed wraps; 0 ignores OverflowIn.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset, shared with the upstream counter.
- Clr  input  1  synchronous clear of Error/ErrCode/WrapCount; returns the FSM to IDLE.
- GrayIn  input  W  Gray code from the upstream counter's Output.
- OverflowIn  input  1  upstream Overflow flag.
- Bin  output  W  registered binary of the last GrayIn sample.
- Step  output  1  one-cycle pulse on a legal forward step.
- WrapCount  output  WCNT_W  number of legal wraps from max code to 0; saturates at all-ones.
- Error  output  1  sticky violation flag.
- ErrCode  output  2  first violation cause: 00 none, 01 multi-bit jump, 10 backward step, 11 overflow mismatch.

Behaviour:
- Reset (asynchronous, immediate) sets every output and register to 0, clears PrevGray, clears SeenWrap and puts the FSM in IDLE. This applies mid-sequence with no other condition.
- Gray-to-binary conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
- Bin is registered, so it reflects GrayIn sampled at the previous edge (latency 1).
- Legal sequence for W=3: 000,001,011,010,110,111,101,100, then back to 000.
- Classification of each sample, by the binary difference d = Bin(cur) - Bin(prev), computed mod 2**W:
  - d=0: hold.
  - d=1: forward step.
  - d=2**W-1: backward step, error 10.
  - any other d: jump, error 01.
- A forward step from max code to 0 is a wrap.
- IDLE: the first sample after Reset or Clr loads PrevGray and Bin with no check, then the FSM moves to TRACK.
- TRACK, per sample:
  - Forward step: Step=1 on the next cycle.
  - Wrap: additionally WrapCount+1 (saturating) and SeenWrap=1.
  - Overflow check, when OVF_CHECK=1: OverflowIn must equal SeenWrap after the update of the same sample, i.e. it rises on the wrap sample and stays high until Reset. Any mismatch gives error 11.
  - On any error: Error=1, ErrCode latched, FSM moves to FAULT.
- Error priority on the same sample: jump (01) > backward (10) > overflow (11).
- FAULT:
  - Bin keeps updating.
  - Step stays 0; WrapCount freezes.
  - Error and ErrCode hold.
  - Only Reset or Clr leaves FAULT.
- Clr together with an error on the same edge: Clr wins; the state becomes IDLE.
- Clr does not clear SeenWrap. Only Reset clears it, matching the sticky upstream flag.
- WrapCount at all-ones stays at all-ones; no error is raised for saturation.

Decomposition:
- Package gray_mon_pkg holds:
  - the state encoding IDLE=2'd0, TRACK=2'd1, FAULT=2'd2;
  - the ErrCode constants ERR_NONE, ERR_JUMP, ERR_BACK, ERR_OVF;
  - a function gray2bin(W).
- One sub-module, gray2bin_w: purely combinational, parameter W, instanced once for GrayIn.
- The FSM, counters and checks live in gray_seq_monitor.

Test Plan:
- Reset high for 30 ns, then drive the full legal sequence 000→…→100→000 with OverflowIn rising on the 000 sample → 8 Step pulses, WrapCount=1, Error=0, and Bin follows 0..7 then 0, one cycle late.
- Hold GrayIn=011 for 5 cycles mid-sequence → Step=0, Bin=2 throughout, Error=0.
- Inject 001→010 (binary 1→3) → Error=1, ErrCode=01 one cycle later, Step=0, WrapCount frozen; Clr pulse then legal codes → Error=0, FSM back in TRACK.
- Inject 011→001 (binary 2→1) → ErrCode=10; a later jump does not overwrite ErrCode.
- With OVF_CHECK=1: wrap 100→000 with OverflowIn held 0 → ErrCode=11. With OverflowIn=1 before any wrap → ErrCode=11. Repeat with OVF_CHECK=0 → no error.
- 300 legal wraps with WCNT_W=8 → WrapCount saturates at 255; Reset asserted mid-cycle → all outputs 0 immediately, asynchronous to Clk.
